// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use and mult/div busy stalls, redirect flush,
// multiply/divide busy-window tracking and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idValid,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUseRs,
  input  logic        idUseRt,
  input  logic        idReadsHiLo,
  input  logic        idIsMulDiv,
  input  logic [4:0]  exWriteReg,
  input  logic        exMemRead,
  input  logic        exStartMulDiv,
  input  logic        exIsDiv,
  input  logic        exRedirect,
  output logic        pcStall,
  output logic        ifidStall,
  output logic        idexBubble,
  output logic        ifidFlush,
  output logic        mdBusy,
  output logic [5:0]  mdCount,
  output logic        mdDone,
  output logic [31:0] stallCycles
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } md_state_t;

  localparam logic [5:0] C_MULT_LEN = 6'(MULT_CYCLES);
  localparam logic [5:0] C_DIV_LEN  = 6'(DIV_CYCLES);

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [5:0]  r_count;
  logic [5:0]  w_count_nxt;
  logic [5:0]  w_start_len;
  logic        w_done;
  logic [31:0] r_stall_cnt;

  logic w_load_use;
  logic w_md_hazard;
  logic w_stall;

  assign mdBusy = (r_count != '0);

  always_comb begin
    w_load_use  = idValid & exMemRead & (exWriteReg != '0) &
                  ((idUseRs & (idRs == exWriteReg)) |
                   (idUseRt & (idRt == exWriteReg)));
    w_md_hazard = idValid & mdBusy & (idReadsHiLo | idIsMulDiv);
    // A redirect kills the wrong-path ID instruction, so it never stalls.
    w_stall     = (w_load_use | w_md_hazard) & ~exRedirect;
  end

  assign pcStall    = w_stall;
  assign ifidStall  = w_stall;
  assign idexBubble = w_stall | exRedirect;
  assign ifidFlush  = exRedirect;

  assign w_start_len = exIsDiv ? C_DIV_LEN : C_MULT_LEN;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (exStartMulDiv) begin
          w_state_nxt = S_BUSY;
          w_count_nxt = w_start_len;
        end
      end
      S_BUSY: begin
        if (exStartMulDiv) begin
          w_count_nxt = w_start_len;
        end else begin
          w_count_nxt = r_count - 6'd1;
          if (r_count == 6'd1) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign mdDone      = w_done;
  assign mdCount     = r_count;
  assign stallCycles = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_hazard_stall_unit;

  localparam int unsigned MULT_N = 4;
  localparam int unsigned DIV_N  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        idValid;
  logic [4:0]  idRs, idRt;
  logic        idUseRs, idUseRt, idReadsHiLo, idIsMulDiv;
  logic [4:0]  exWriteReg;
  logic        exMemRead, exStartMulDiv, exIsDiv, exRedirect;
  logic        pcStall, ifidStall, idexBubble, ifidFlush, mdBusy, mdDone;
  logic [5:0]  mdCount;
  logic [31:0] stallCycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: remaining busy cycles and total stalled cycles.
  int          m_rem    = 0;
  longint      m_stalls = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUseRs(idUseRs), .idUseRt(idUseRt), .idReadsHiLo(idReadsHiLo),
    .idIsMulDiv(idIsMulDiv), .exWriteReg(exWriteReg), .exMemRead(exMemRead),
    .exStartMulDiv(exStartMulDiv), .exIsDiv(exIsDiv), .exRedirect(exRedirect),
    .pcStall(pcStall), .ifidStall(ifidStall), .idexBubble(idexBubble),
    .ifidFlush(ifidFlush), .mdBusy(mdBusy), .mdCount(mdCount), .mdDone(mdDone),
    .stallCycles(stallCycles)
  );

  function automatic bit m_load_use();
    bit rs_hit = idUseRs && (idRs == exWriteReg);
    bit rt_hit = idUseRt && (idRt == exWriteReg);
    return idValid && exMemRead && (exWriteReg != 0) && (rs_hit || rt_hit);
  endfunction

  function automatic bit m_stall();
    bit md_haz = idValid && (m_rem > 0) && (idReadsHiLo || idIsMulDiv);
    return (m_load_use() || md_haz) && !exRedirect;
  endfunction

  function automatic bit m_done();
    return (m_rem == 1) && !exStartMulDiv;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; idValid = 1'b0; idRs = '0; idRt = '0; idUseRs = 1'b0;
    idUseRt = 1'b0; idReadsHiLo = 1'b0; idIsMulDiv = 1'b0; exWriteReg = '0;
    exMemRead = 1'b0; exStartMulDiv = 1'b0; exIsDiv = 1'b0; exRedirect = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_rem = 0;
      m_stalls = 0;
    end else begin
      if (m_stall() && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (exStartMulDiv) m_rem = exIsDiv ? DIV_N : MULT_N;
      else if (m_rem > 0) m_rem--;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mdBusy, mdDone, mdCount} !== 8'h00) begin
      n_fail++; $display("FAIL reset_md: got busy=%b done=%b cnt=%0d want 0/0/0", mdBusy, mdDone, mdCount);
    end
    n_checks++;
    if (stallCycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_stalls: got %0d want 0", stallCycles);
    end
    n_checks++;
    if ({pcStall, ifidStall, idexBubble, ifidFlush} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000", {pcStall, ifidStall, idexBubble, ifidFlush});
    end
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    clear_inputs();
    base = stallCycles;
    idValid = 1'b1; idRs = 5'd3; idUseRs = 1'b1; exMemRead = 1'b1; exWriteReg = 5'd3;
    #1;
    n_checks++;
    if ({pcStall, ifidStall, idexBubble, ifidFlush} !== 4'b1110) begin
      n_fail++; $display("FAIL lu_stall: got %b want 1110", {pcStall, ifidStall, idexBubble, ifidFlush});
    end
    tick();
    exMemRead = 1'b0; exWriteReg = '0;   // load moved on, bubble now in EX
    #1;
    n_checks++;
    if ({pcStall, idexBubble} !== 2'b00) begin
      n_fail++; $display("FAIL lu_release: got %b want 00", {pcStall, idexBubble});
    end
    n_checks++;
    if (stallCycles !== base + 32'd1) begin
      n_fail++; $display("FAIL lu_count: got %0d want %0d", stallCycles, base + 32'd1);
    end
    exMemRead = 1'b1; exWriteReg = 5'd0; idRs = 5'd0;
    #1;
    n_checks++;
    if (pcStall !== 1'b0) begin
      n_fail++; $display("FAIL lu_r0: got %b want 0", pcStall);
    end
    exWriteReg = 5'd3; idRs = 5'd3; idUseRs = 1'b0;
    #1;
    n_checks++;
    if (pcStall !== 1'b0) begin
      n_fail++; $display("FAIL lu_unused_rs: got %b want 0", pcStall);
    end
    idRt = 5'd3; idUseRt = 1'b1;
    #1;
    n_checks++;
    if (pcStall !== 1'b1) begin
      n_fail++; $display("FAIL lu_rt: got %b want 1", pcStall);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mult();
    clear_inputs();
    exStartMulDiv = 1'b1; exIsDiv = 1'b0;
    #1;
    n_checks++;
    if (mdBusy !== 1'b0) begin
      n_fail++; $display("FAIL mul_issue_busy: got %b want 0", mdBusy);
    end
    tick();
    exStartMulDiv = 1'b0;
    idValid = 1'b1; idReadsHiLo = 1'b1;
    for (int k = 0; k < int'(MULT_N); k++) begin
      #1;
      n_checks++;
      if ({mdCount, pcStall, mdBusy, mdDone} !== {6'(MULT_N - k), 1'b1, 1'b1, 1'(k == int'(MULT_N) - 1)}) begin
        n_fail++; $display("FAIL mul_cycle%0d: got cnt=%0d stall=%b busy=%b done=%b want cnt=%0d 1 1 %b",
                           k, mdCount, pcStall, mdBusy, mdDone, MULT_N - k, k == int'(MULT_N) - 1);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({mdCount, pcStall, mdBusy, mdDone} !== 9'b0) begin
      n_fail++; $display("FAIL mul_release: got cnt=%0d stall=%b busy=%b done=%b want all 0", mdCount, pcStall, mdBusy, mdDone);
    end
    clear_inputs();
  endtask

  task automatic test_div();
    logic [31:0] base;
    int stalled;
    clear_inputs();
    // Second div arrives in ID while the first issues: no stall yet.
    exStartMulDiv = 1'b1; exIsDiv = 1'b1; idValid = 1'b1; idIsMulDiv = 1'b1;
    #1;
    n_checks++;
    if (pcStall !== 1'b0) begin
      n_fail++; $display("FAIL div_same_cycle: got %b want 0", pcStall);
    end
    base = stallCycles;
    tick();
    exStartMulDiv = 1'b0; exIsDiv = 1'b0;
    stalled = 0;
    for (int k = 0; k < 40 && pcStall === 1'b1; k++) begin
      stalled++;
      tick();
      #1;
    end
    n_checks++;
    if (stalled != int'(DIV_N)) begin
      n_fail++; $display("FAIL div_stall_len: got %0d want %0d", stalled, DIV_N);
    end
    n_checks++;
    if (stallCycles !== base + 32'(DIV_N)) begin
      n_fail++; $display("FAIL div_count: got %0d want %0d", stallCycles, base + 32'(DIV_N));
    end
    clear_inputs();
  endtask

  task automatic test_redirect();
    logic [31:0] base;
    clear_inputs();
    base = stallCycles;
    idValid = 1'b1; idRs = 5'd5; idUseRs = 1'b1; exMemRead = 1'b1; exWriteReg = 5'd5;
    exRedirect = 1'b1;
    #1;
    n_checks++;
    if ({pcStall, ifidStall, idexBubble, ifidFlush} !== 4'b0011) begin
      n_fail++; $display("FAIL redir_ctl: got %b want 0011", {pcStall, ifidStall, idexBubble, ifidFlush});
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (stallCycles !== base) begin
      n_fail++; $display("FAIL redir_count: got %0d want %0d", stallCycles, base);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    exStartMulDiv = 1'b1; exIsDiv = 1'b1;
    tick();
    exStartMulDiv = 1'b0; exIsDiv = 1'b0;
    for (int k = 0; k < 40 && mdCount !== 6'd10; k++) tick();
    n_checks++;
    if (mdCount !== 6'd10) begin
      n_fail++; $display("FAIL rmid_reach: got %0d want 10", mdCount);
    end
    reset = 1'b1; idValid = 1'b1; idReadsHiLo = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mdCount, mdBusy, pcStall} !== 8'b0) begin
      n_fail++; $display("FAIL rmid_state: got cnt=%0d busy=%b stall=%b want 0/0/0", mdCount, mdBusy, pcStall);
    end
    n_checks++;
    if (stallCycles !== 32'd0) begin
      n_fail++; $display("FAIL rmid_stalls: got %0d want 0", stallCycles);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [4:0] exp_ctl;
    for (int c = 0; c < 2000; c++) begin
      reset         = ($urandom_range(0, 99) == 0);
      idValid       = ($urandom_range(0, 3) != 0);
      idRs          = 5'($urandom_range(0, 3));
      idRt          = 5'($urandom_range(0, 3));
      idUseRs       = 1'($urandom);
      idUseRt       = 1'($urandom);
      idReadsHiLo   = ($urandom_range(0, 3) == 0);
      idIsMulDiv    = ($urandom_range(0, 5) == 0);
      exWriteReg    = 5'($urandom_range(0, 3));
      exMemRead     = ($urandom_range(0, 2) == 0);
      exStartMulDiv = (m_rem == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
      exIsDiv       = ($urandom_range(0, 3) == 0);
      exRedirect    = ($urandom_range(0, 7) == 0);
      #1;
      exp_ctl = {m_stall(), m_stall(), m_stall() | exRedirect, exRedirect, m_done()};
      n_checks++;
      if ({pcStall, ifidStall, idexBubble, ifidFlush, mdDone} !== exp_ctl) begin
        n_fail++; $display("FAIL rnd_ctl c%0d: got %b want %b", c, {pcStall, ifidStall, idexBubble, ifidFlush, mdDone}, exp_ctl);
      end
      n_checks++;
      if ({mdBusy, mdCount} !== {1'(m_rem > 0), 6'(m_rem)}) begin
        n_fail++; $display("FAIL rnd_md c%0d: got busy=%b cnt=%0d want %b %0d", c, mdBusy, mdCount, m_rem > 0, m_rem);
      end
      n_checks++;
      if (stallCycles !== 32'(m_stalls)) begin
        n_fail++; $display("FAIL rnd_stalls c%0d: got %0d want %0d", c, stallCycles, m_stalls);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mult();
    test_div();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
